// File: rtl/socetlib_edge_capture.sv
// Multi-channel edge capture: synchronize, debounce, detect edges and latch sticky
// per-channel event/overrun flags with a combined interrupt.
module socetlib_edge_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] signal,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pos_edge,
  output logic [WIDTH-1:0] neg_edge,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overrun,
  output logic             irq
);

  localparam int               CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [WIDTH-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = signal;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_reg [SYNC_STAGES];

      always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_reg[k] <= '0;
        end else begin
          sync_reg[0] <= signal;
          for (int k = 1; k < SYNC_STAGES; k++) sync_reg[k] <= sync_reg[k-1];
        end
      end

      assign s = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             f_reg, f_next;
      logic             accept;
      logic             pos_reg, neg_reg;
      logic             pending_reg, overrun_reg;
      logic             event_w, ovr_cond;

      // Counter tracks consecutive cycles s disagrees with the filtered level.
      always_comb begin
        accept   = 1'b0;
        cnt_next = '0;
        f_next   = f_reg;
        if (s[gi] != f_reg) begin
          if (cnt_reg == CNT_MAX) begin
            accept = 1'b1;
            f_next = s[gi];
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      assign event_w  = (pos_reg & rise_en[gi]) | (neg_reg & fall_en[gi]);
      assign ovr_cond = event_w & pending_reg & ~clear[gi];

      always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
          cnt_reg     <= '0;
          f_reg       <= 1'b0;
          pos_reg     <= 1'b0;
          neg_reg     <= 1'b0;
          pending_reg <= 1'b0;
          overrun_reg <= 1'b0;
        end else begin
          cnt_reg     <= cnt_next;
          f_reg       <= f_next;
          pos_reg     <= accept & s[gi];
          neg_reg     <= accept & ~s[gi];
          // A new event outranks a simultaneous clear.
          pending_reg <= event_w | (pending_reg & ~clear[gi]);
          overrun_reg <= ovr_cond | (overrun_reg & ~clear[gi]);
        end
      end

      assign level[gi]    = f_reg;
      assign pos_edge[gi] = pos_reg;
      assign neg_edge[gi] = neg_reg;
      assign pending[gi]  = pending_reg;
      assign overrun[gi]  = overrun_reg;
    end
  endgenerate

  assign irq = |pending;

endmodule

// File: doc/socetlib_edge_capture.md
SOCETLIB_EDGE_CAPTURE -- requirements
Module: socetlib_edge_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, number of independent channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per channel (0..3; 0 = input used directly).
REQ-003 The block SHALL have parameter DEBOUNCE, default 4, consecutive cycles a new level must persist before acceptance (1..255).
REQ-004 The block SHALL have input CLK, 1 bit, clock; all state updates on its rising edge.
REQ-005 The block SHALL have input nRST, 1 bit, reset: asynchronous, active-low.
REQ-006 The block SHALL have input signal, WIDTH bits, raw, possibly asynchronous and bouncing channel levels.
REQ-007 The block SHALL have input rise_en, WIDTH bits, per-channel enable for rising-edge capture.
REQ-008 The block SHALL have input fall_en, WIDTH bits, per-channel enable for falling-edge capture.
REQ-009 The block SHALL have input clear, WIDTH bits, per-channel write-1-to-clear for pending and overrun.
REQ-010 The block SHALL have output level, WIDTH bits, debounced channel level.
REQ-011 The block SHALL have outputs pos_edge and neg_edge, WIDTH bits each, one-cycle pulses on accepted transitions.
REQ-012 The block SHALL have output pending, WIDTH bits, sticky captured-event flags.
REQ-013 The block SHALL have output overrun, WIDTH bits, sticky flags for events lost while pending.
REQ-014 The block SHALL have output irq, 1 bit, OR-reduction of pending.

Function
REQ-015 Each channel SHALL pass signal through SYNC_STAGES flops; s denotes the last stage output, or signal itself when SYNC_STAGES = 0.
REQ-016 Each channel SHALL hold a debounce counter of max(1, clog2(DEBOUNCE)) bits and a filtered level register f driving level.
REQ-017 On each edge: if s == f, counter SHALL load 0 and f SHALL hold.
REQ-018 On each edge: if s != f and counter == DEBOUNCE-1, f SHALL load s and counter SHALL load 0 (accept).
REQ-019 On each edge: if s != f and counter < DEBOUNCE-1, counter SHALL increment and f SHALL hold.
REQ-020 A level on s lasting fewer than DEBOUNCE consecutive cycles SHALL produce no level change and no edge pulse.
REQ-021 pos_edge[i] SHALL be registered, high for exactly one cycle (the first cycle f[i] shows 1) after an accept to 1.
REQ-022 neg_edge[i] SHALL behave the same as pos_edge[i] for an accept to 0.
REQ-023 Latency from a stable input change set up before edge 1 to the edge pulse and new level SHALL be SYNC_STAGES + DEBOUNCE cycles (6 at defaults).
REQ-024 The minimum spacing between successive accepted transitions on one channel SHALL be DEBOUNCE cycles.
REQ-025 event[i] SHALL equal (pos_edge[i] & rise_en[i]) | (neg_edge[i] & fall_en[i]); with both enables high, both edge directions capture.
REQ-026 pending[i] SHALL set on the edge after event[i], and SHALL clear on the edge after clear[i] when event[i] is low.
REQ-027 When event[i] and clear[i] occur in the same cycle, pending[i] SHALL end at 1 (set wins).
REQ-028 overrun[i] SHALL set when event[i] & pending[i] & ~clear[i] occurs, and SHALL clear with clear[i] when no such overrun condition occurs that cycle.
REQ-029 Enable changes SHALL affect capture only; level, pos_edge and neg_edge SHALL be unaffected by rise_en and fall_en.
REQ-030 irq SHALL be combinational from pending, with no added latency.
REQ-031 Channels SHALL be fully independent; simultaneous events on any channels SHALL all be captured.

Reset
REQ-032 While nRST is low, all synchronizer flops, counters, f, pos_edge, neg_edge, pending and overrun SHALL be 0, and irq SHALL be 0.
REQ-033 Reset assertion SHALL take effect immediately, independent of CLK, including mid-debounce; partial counts SHALL be discarded.
REQ-034 After release, an input held high SHALL be treated as a rising transition from 0: pos_edge fires SYNC_STAGES + DEBOUNCE cycles after the first edge.

Verification
REQ-035 Defaults, signal[0] 0->1 before edge 1, rise_en[0]=1 -> pos_edge[0] high only in cycle 6, level[0]=1 from cycle 6, pending[0]=1 and irq=1 from cycle 7.
REQ-036 Defaults, signal[3] high for 3 cycles, then low -> no pos_edge or neg_edge, level[3] stays 0, counter returns to 0.
REQ-037 Channel 1, rise_en=1, fall_en=0, clean 0->1->0 with 10-cycle high -> pending set by the rise only; neg_edge[1] pulses but pending is unaffected after a clear.
REQ-038 A second event while pending[2]=1 -> overrun[2]=1; clear[2] in the same cycle as a third event -> pending[2]=1, overrun[2]=0.
REQ-039 nRST pulsed low mid-debounce (counter=2) -> all outputs 0 at once; no edge pulse from the interrupted transition.
REQ-040 SYNC_STAGES=0, DEBOUNCE=1 -> pos_edge fires 1 cycle after the change; all WIDTH channels toggled together all pulse in the same cycle.
